// File: rtl/issue_queue_mp_if.sv
// rtl/issue_queue_mp_if.sv - decode/issue side signal bundle for the multi-port issue queue
interface issue_queue_mp_if #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 16,
    parameter int PUSH_LANES = 4,
    parameter int POP_LANES  = 2
);
    logic                             flash;
    logic                             hold;
    logic [PUSH_LANES*DATA_W-1:0]     in_data;
    logic [$clog2(PUSH_LANES+1)-1:0]  in_num;
    logic [$clog2(POP_LANES+1)-1:0]   out_num;
    logic [POP_LANES*DATA_W-1:0]      out_data;
    logic [POP_LANES-1:0]             out_valid;
    logic [$clog2(DEPTH+1)-1:0]       size;
    logic [$clog2(DEPTH+1)-1:0]       size_left;
    logic                             almost_full;
    logic                             err_ovf;
    logic                             err_udf;

    modport master (
        output flash, hold, in_data, in_num, out_num,
        input  out_data, out_valid, size, size_left, almost_full, err_ovf, err_udf
    );

    modport slave (
        input  flash, hold, in_data, in_num, out_num,
        output out_data, out_valid, size, size_left, almost_full, err_ovf, err_udf
    );
endinterface

// File: rtl/issue_queue_mp.sv
// rtl/issue_queue_mp.sv - multi-port circular issue queue between decode and issue
module issue_queue_mp #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 16,
    parameter int PUSH_LANES = 4,
    parameter int POP_LANES  = 2,
    parameter int AF_THRESH  = 4
) (
    input logic              clk,
    input logic              rst_n,
    issue_queue_mp_if.slave  iq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("issue_queue_mp: DEPTH must be a power of two >= 2");
        end
        if (PUSH_LANES > DEPTH || POP_LANES > DEPTH) begin : g_bad_lanes
            $error("issue_queue_mp: lane counts must not exceed DEPTH");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;
    logic [CNT_W-1:0]  free_w, in_num_w, out_num_w, push_eff, pop_eff;

    // Free space uses the pre-pop count: slots freed this cycle are not reusable yet.
    always_comb begin
        free_w    = CNT_W'(DEPTH) - count_q;
        in_num_w  = CNT_W'(iq.in_num);
        out_num_w = CNT_W'(iq.out_num);
        push_eff  = (in_num_w > free_w) ? free_w : in_num_w;
        pop_eff   = iq.hold ? '0 : ((out_num_w > count_q) ? count_q : out_num_w);

        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;
        if (iq.flash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d    = head_q + pop_eff[PTR_W-1:0];
            tail_d    = tail_q + push_eff[PTR_W-1:0];
            count_d   = count_q + push_eff - pop_eff;
            err_ovf_d = err_ovf_q | (in_num_w > free_w);
            err_udf_d = err_udf_q | (!iq.hold && (out_num_w > count_q));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    // Storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PUSH_LANES; k++) begin
            if (!iq.flash && (CNT_W'(k) < push_eff)) begin
                mem_q[tail_q + PTR_W'(k)] <= iq.in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < POP_LANES; i++) begin
            iq.out_data[i*DATA_W +: DATA_W] = mem_q[head_q + PTR_W'(i)];
            iq.out_valid[i]                 = int'(count_q) > i;
        end
        iq.size        = count_q;
        iq.size_left   = CNT_W'(DEPTH) - count_q;
        iq.almost_full = int'(CNT_W'(DEPTH) - count_q) < AF_THRESH;
        iq.err_ovf     = err_ovf_q;
        iq.err_udf     = err_udf_q;
    end
endmodule
